// File: rtl/processorci_bus_bridge.sv
// Bus bridge: arbitrates a core's instruction and data ports onto one shared memory port,
// steering byte lanes, rejecting illegal accesses and bounding every wait for mem_ack.
//
// state  | meaning
// IDLE   | sample and arbitrate instruction / data requests
// MEM    | strobe held, waiting for mem_ack or timeout
// RESP   | one-cycle ack (and err) to the granted port
module processorci_bus_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int ARB_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    output logic                    i_ack,
    output logic                    i_err,
    input  logic                    d_rd,
    input  logic                    d_wr,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [1:0]              d_size,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_ack,
    output logic                    d_err,
    output logic                    mem_rd,
    output logic                    mem_wr,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ack
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int OW = $clog2(NB);
    localparam logic [1:0]            MAX_SIZE  = 2'(OW);
    localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'((1 << OW) - 1);
    localparam bit                    TO_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0]           TO_LAST   = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_MEM, S_RESP} state_t;
    state_t state, state_nx;

    logic                  last_d;
    logic                  grant_d;
    logic [OW-1:0]         off_q;
    logic [1:0]            size_q;
    logic [15:0]           to_cnt;

    logic                  d_pend;
    logic                  pick_d;
    logic                  pick_i;
    logic                  d_illegal;
    logic                  timeout_hit;
    logic [OW-1:0]         d_off;
    logic [OW-1:0]         align_mask;
    logic [NB-1:0]         strb_calc;
    logic [DATA_WIDTH-1:0] rd_shift;
    logic [DATA_WIDTH-1:0] rdata_ext;

    assign d_pend      = d_rd | d_wr;
    assign d_off       = d_addr[OW-1:0];
    // Round-robin only matters on a tie: data yields if it won the previous grant.
    assign pick_d      = d_pend && (!i_req || (ARB_MODE == 0) || !last_d);
    assign pick_i      = i_req && !pick_d;
    assign timeout_hit = TO_EN && (to_cnt == TO_LAST);
    assign rd_shift    = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        align_mask = '0;
        strb_calc  = '0;
        rdata_ext  = '0;
        d_illegal  = 1'b0;
        for (int b = 0; b < OW; b++)
            align_mask[b] = (b < int'(d_size));
        for (int b = 0; b < NB; b++) begin
            strb_calc[b] = (b >= int'(d_off)) && (b < int'(d_off) + (1 << d_size));
            if (b < (1 << size_q))
                rdata_ext[8*b +: 8] = rd_shift[8*b +: 8];
        end
        d_illegal = (d_rd & d_wr) | (d_size > MAX_SIZE) | (|(d_off & align_mask));
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (pick_d && d_illegal)
                    state_nx = S_RESP;
                else if (pick_d || pick_i)
                    state_nx = S_MEM;
            end
            S_MEM: begin
                if (mem_ack || timeout_hit)
                    state_nx = S_RESP;
            end
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            i_ack     <= 1'b0;
            i_err     <= 1'b0;
            i_rdata   <= '0;
            d_ack     <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= '0;
            last_d    <= 1'b0;
            grant_d   <= 1'b0;
            off_q     <= '0;
            size_q    <= '0;
            to_cnt    <= '0;
        end else begin
            i_ack <= 1'b0;
            i_err <= 1'b0;
            d_ack <= 1'b0;
            d_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_d) begin
                        last_d  <= 1'b1;
                        grant_d <= 1'b1;
                        if (d_illegal) begin
                            d_ack   <= 1'b1;
                            d_err   <= 1'b1;
                            d_rdata <= '0;
                        end else begin
                            mem_rd    <= d_rd;
                            mem_wr    <= d_wr;
                            mem_addr  <= d_addr & ~LANE_MASK;
                            mem_wdata <= d_wr ? (d_wdata << {d_off, 3'b000}) : '0;
                            mem_wstrb <= d_wr ? strb_calc : '1;
                            off_q     <= d_off;
                            size_q    <= d_size;
                            to_cnt    <= '0;
                        end
                    end else if (pick_i) begin
                        last_d    <= 1'b0;
                        grant_d   <= 1'b0;
                        mem_rd    <= 1'b1;
                        mem_wr    <= 1'b0;
                        mem_addr  <= i_addr & ~LANE_MASK;
                        mem_wdata <= '0;
                        mem_wstrb <= '1;
                        off_q     <= '0;
                        size_q    <= MAX_SIZE;
                        to_cnt    <= '0;
                    end
                end
                S_MEM: begin
                    // mem_ack takes precedence over a timeout reached on the same edge.
                    if (mem_ack || timeout_hit) begin
                        mem_rd    <= 1'b0;
                        mem_wr    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        mem_wstrb <= '0;
                        if (grant_d) begin
                            d_ack   <= 1'b1;
                            d_err   <= !mem_ack;
                            d_rdata <= (mem_ack && mem_rd) ? rdata_ext : '0;
                        end else begin
                            i_ack   <= 1'b1;
                            i_err   <= !mem_ack;
                            i_rdata <= mem_ack ? mem_rdata : '0;
                        end
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/processorci_bus_bridge.md
# processorci_bus_bridge

Parametrised arbiter/adapter between a core's separate instruction and data ports and a single shared memory port on the controller side. It replaces direct, unstrobed wiring of core data signals with proper request/acknowledge handshakes. It generates byte strobes and aligned write data from access size and address offset, extracts read data, detects illegal or misaligned accesses, and bounds every memory transaction with a timeout. It sits between the core instance and the controller's memory interface inside the top-level wrapper.

## Interface
- `ADDR_WIDTH`, 32, address width on all ports.
- `DATA_WIDTH`, 32, data width on all ports; must be 32 or 64. Derived: `NB = DATA_WIDTH/8`, `OW = log2(NB)`.
- `ARB_MODE`, 0, arbitration mode: 0 = fixed priority with data over instruction; 1 = round-robin.
- `TIMEOUT_CYCLES`, 255, maximum wait cycles for `mem_ack`; 0 disables the timeout. The timeout counter is 16 bits.

- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `i_req` in 1: instruction fetch request; held until `i_ack`.
- `i_addr` in ADDR_WIDTH: fetch address.
- `i_rdata` out DATA_WIDTH: fetched word, valid while `i_ack`=1.
- `i_ack` out 1: one-cycle completion pulse.
- `i_err` out 1: error flag, valid with `i_ack`.
- `d_rd`, `d_wr` in 1: data read / write request; held until `d_ack`.
- `d_addr` in ADDR_WIDTH: byte address.
- `d_size` in 2: log2 of access bytes (0 = byte, 1 = half, 2 = word, 3 = dword).
- `d_wdata` in DATA_WIDTH: write data, right-justified.
- `d_rdata` out DATA_WIDTH: read data, right-justified and zero-extended.
- `d_ack` out 1: one-cycle completion pulse.
- `d_err` out 1: error flag, valid with `d_ack`.
- `mem_rd`, `mem_wr` out 1: memory strobes, held until `mem_ack`.
- `mem_addr` out ADDR_WIDTH: address with the low OW bits cleared.
- `mem_wdata` out DATA_WIDTH: lane-shifted write data.
- `mem_wstrb` out NB: byte enables; all ones on reads.
- `mem_rdata` in DATA_WIDTH: memory read data, sampled with `mem_ack`.
- `mem_ack` in 1: memory completion.

## Operation
- FSM states:
  - IDLE: samples requests.
  - MEM: a strobe is asserted and the block waits for `mem_ack`.
  - RESP: exactly one cycle; asserts `i_ack` or `d_ack`.
  - RESP always returns to IDLE. Requests still held high during RESP are ignored.
- Arbitration in IDLE:
  - A data request is pending when `d_rd|d_wr`.
  - Mode 0: data wins over instruction.
  - Mode 1: when both are pending, grant the port not granted last. The last-grant bit resets to "instruction", so data wins the first tie.
- Illegal data requests:
  - Conditions: `d_rd&d_wr`; `d_size` greater than OW; or `d_addr` not aligned to `1<<d_size`.
  - Response: IDLE→RESP with `d_err`=1 and `d_rdata`=0. No memory strobe is issued.
  - Illegal requests still count as a grant for round-robin.
- Instruction fetch: `mem_rd`=1, `mem_wstrb`=all ones. `i_addr` low OW bits are ignored.
- Data write, with `off = d_addr[OW-1:0]`:
  - `mem_wdata = d_wdata << (8*off)`.
  - `mem_wstrb = ((1<<(1<<d_size))-1) << off`.
- Data read: `d_rdata = (mem_rdata >> (8*off))`, masked to `8<<d_size` bits with upper bits zero.
- Request fields (address, size, offset, write data) are captured in registers on the IDLE→MEM transition. Later changes on the input ports do not affect the transaction.
- Timeout:
  - The counter clears on entering MEM and increments each MEM cycle without `mem_ack`.
  - If the count reaches TIMEOUT_CYCLES (when nonzero), the strobes drop and the FSM enters RESP with err=1 and rdata=0.
  - If `mem_ack` arrives on the same edge the timeout is reached, `mem_ack` wins and the access completes normally.
- Reset (any time, including mid-MEM):
  - Next edge: state IDLE; all outputs 0; `mem_addr`/`mem_wdata`=0; counter 0; last-grant = instruction.
  - An abandoned memory transaction is not replayed.

## Timing
- Edge E0 samples a request in IDLE. Strobes and address are registered and visible after E0.
- `mem_ack` is sampled at edge E0+k (k≥1). Read data is captured and the strobes deassert after that edge.
- `*_ack`/`*_err`/`*_rdata` are high during the cycle after E0+k, i.e. for one cycle only.
- Minimum latency from request-sampled to ack = 2 cycles.
- Maximum issue rate: one transaction per 3 cycles.
- An illegal request is acked in the cycle after E0, i.e. latency 1.
- `*_rdata` holds its value until the next ack on the same port.
- `*_err` is 0 except during an error ack.
- `mem_wstrb` and `mem_wdata` are 0 outside MEM.

## Test plan
- Word fetch: `i_req`, `i_addr`=0x104, `mem_rdata`=0xDEADBEEF, `mem_ack` one cycle after `mem_rd`.
  - Required: `mem_addr`=0x104, `i_ack` single pulse 2 cycles after sampling, `i_rdata`=0xDEADBEEF, `i_err`=0.
- Byte write (DATA_WIDTH=32): `d_wr`, `d_addr`=0x203, `d_size`=0, `d_wdata`=0xA5.
  - Required: `mem_addr`=0x200, `mem_wstrb`=4'b1000, `mem_wdata`=0xA5000000.
- Half read: `d_addr`=0x12, `d_size`=1, `mem_rdata`=0x8765_4321.
  - Required: `d_rdata`=0x0000_8765.
- Misaligned half read: `d_addr`=0x13, `d_size`=1.
  - Required: no `mem_rd`; `d_ack`+`d_err` one cycle later; `d_rdata`=0.
- Contention: `i_req` and `d_rd` held together for 4 transactions, ARB_MODE=1.
  - Required grant order D, I, D, I.
  - With ARB_MODE=0 the grant order is D, D (instruction starves while data is held).
- Timeout: TIMEOUT_CYCLES=4, `mem_ack` never asserted.
  - Required: `mem_rd` high for exactly 4 cycles, then `d_ack`+`d_err`.
  - Then assert `reset` during a second MEM phase: all outputs 0 on the next edge and the FSM is in IDLE.
